light_sequencer: RTL and testbench
==================================

# light_sequencer

Control block that drives the lights selector's `button` and `sel` inputs so the light plays a programmed pattern without a human pressing the button. On a `start` pulse it latches a mode, a dwell time and a step count, then issues single-cycle `button` advances and/or `sel` white-override phases on a dwell-timer cadence. It reports `busy` while active and pulses `done` on completion. It sits between the board-level control registers and the selector.

## Interface
- `DWELL_W`, default 8: width of the dwell-time input and internal dwell counter.
- `STEP_W`, default 4: width of the step-count input and `step_cnt` output.
- `clk` in 1: one clock, all state on rising edge.
- `rst` in 1: reset is asynchronous and active-low.
- `start` in 1: request to begin a sequence; sampled only in IDLE.
- `stop` in 1: abort the current sequence.
- `mode` in 2: 00 STEP, 01 FLASH, 10 HOLD, 11 reserved.
- `dwell` in DWELL_W: cycles per phase, D = max(dwell,1).
- `steps` in STEP_W: colour advances before done; 0 = run until `stop`.
- `button` out 1: one-cycle advance pulse to selector (one colour per high cycle).
- `sel` out 1: white override to selector.
- `busy` out 1: high in STEP/FLASH/HOLD.
- `done` out 1: one-cycle completion pulse.
- `step_cnt` out STEP_W: advances issued in current sequence.

## Operation
- FSM states: IDLE, STEP, FLASH, HOLD, DONE. All outputs registered.
- IDLE: `start`=1 with mode≠11 latches mode/dwell/steps, clears `step_cnt` and dwell counter, moves to the mode's state. `start` with mode 11 is ignored.
- STEP: `sel`=0; each time the dwell counter expires (every D cycles), `button`=1 for one cycle and `step_cnt`+1.
- FLASH: `sel` starts 0 and toggles at each dwell expiry. On every 1→0 toggle, `button` pulses in the same cycle and `step_cnt`+1.
- HOLD: `sel`=1 constant, `button`=0, `steps` ignored. Exits only on `stop`.
- Completion (STEP/FLASH, steps≠0): the cycle after the pulse that makes `step_cnt`==`steps`, go to DONE. DONE: `done`=1, `busy`=0, `sel`=0 for one cycle, then IDLE. `step_cnt` holds its final value until the next `start`.
- steps=0: run indefinitely; `step_cnt` wraps 2^STEP_W-1→0.
- `stop` in any busy state: next state IDLE, `sel`=0, `button`=0, no `done`. `stop` has priority over a dwell expiry in the same cycle (no pulse issued) and over `start` in IDLE.
- `start` while busy or in DONE: ignored. Input changes after `start`: no effect until the next `start`.

## Timing
- Reset (async assert): state IDLE; `button`, `sel`, `busy`, `done`=0; `step_cnt`=0; dwell counter 0. Reset mid-sequence aborts immediately with no `done`.
- `start` sampled at edge N: `busy`=1 from N+1. In HOLD, `sel`=1 from N+1.
- First `button` (STEP) or first `sel` rise (FLASH): edge N+D. Later events every D cycles.
- `done` asserts at the edge after the final pulse and lasts 1 cycle. `busy` falls at that same edge.
- `stop` at edge M: `busy`/`sel`=0 from M+1.

## Structure
- Shared package `light_seq_pkg`: state encoding (IDLE=0, STEP=1, FLASH=2, HOLD=3, DONE=4) and mode constants (MODE_STEP, MODE_FLASH, MODE_HOLD, MODE_RSVD).
- Sub-module `dwell_timer`: loadable down-counter with clear and a one-cycle `tick` every D cycles.
- The top level holds the FSM, step counter and output registers.

## Test plan
- Reset: hold `rst`=0 mid-FLASH with dwell=3 → all outputs 0 immediately; after release, stays IDLE.
- STEP: mode=00, dwell=5, steps=3, `start` at edge 0 → `button` pulses at edges 5, 10, 15; `step_cnt` 1,2,3; `done` at 16; `busy` high 1–15.
- FLASH: mode=01, dwell=2, steps=2 → `sel` rises at 2 and 6, falls at 4 and 8 with `button` at 4 and 8; `done` at 9.
- HOLD + stop: mode=10, `start` at 0 → `sel`=1 from 1. `stop` at 20 → `sel`=0, `busy`=0 at 21, `done` never.
- Boundaries: dwell=0 → pulse every cycle. steps=0, dwell=1 for 20 cycles → `step_cnt` wraps 15→0. `stop` coincident with expiry → no pulse. `start`+`stop` in IDLE → stays IDLE. mode=11 → ignored.

Source files
------------

// File: rtl/light_seq_pkg.sv
// rtl/light_seq_pkg.sv - shared state encoding and mode constants for the light sequencer
package light_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_STEP  = 3'd1,
      ST_FLASH = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [1:0] MODE_STEP  = 2'b00;
   localparam logic [1:0] MODE_FLASH = 2'b01;
   localparam logic [1:0] MODE_HOLD  = 2'b10;
   localparam logic [1:0] MODE_RSVD  = 2'b11;

   // Only meaningful for the three legal modes; callers filter MODE_RSVD first.
   function automatic state_e state_for_mode(input logic [1:0] mode);
      case (mode)
         MODE_STEP:  return ST_STEP;
         MODE_FLASH: return ST_FLASH;
         MODE_HOLD:  return ST_HOLD;
         default:    return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/light_sequencer_dwell_timer.sv
// rtl/light_sequencer_dwell_timer.sv - reloading down-counter, tick_o for one cycle every period_m1_i+1 cycles
module dwell_timer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               en_i,
   input  logic [DWELL_W-1:0] period_m1_i,
   output logic               tick_o
);

   logic [DWELL_W-1:0] cnt_q;

   assign tick_o = en_i && (cnt_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= period_m1_i;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            cnt_q <= period_m1_i;
         end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
         end
      end
   end

endmodule

// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - drives selector button/sel with a programmed STEP, FLASH or HOLD pattern
module light_sequencer
   import light_seq_pkg::*;
#(
   parameter int DWELL_W = 8,
   parameter int STEP_W  = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [1:0]         mode_i,
   input  logic [DWELL_W-1:0] dwell_i,
   input  logic [STEP_W-1:0]  steps_i,
   output logic               button_o,
   output logic               sel_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [STEP_W-1:0]  step_cnt_o
);

   state_e              state_q;
   logic [DWELL_W-1:0]  dwell_q;
   logic [STEP_W-1:0]   steps_q;
   logic [STEP_W-1:0]   step_cnt_q;
   logic                button_q, sel_q, busy_q, done_q;

   logic                accept;
   logic                tick;
   logic [DWELL_W-1:0]  dwell_src;
   logic [DWELL_W-1:0]  period_m1;

   assign accept = (state_q == ST_IDLE) && start_i && !stop_i && (mode_i != MODE_RSVD);

   // The timer is loaded on the start edge itself, before dwell_q holds the new value.
   assign dwell_src = (state_q == ST_IDLE) ? dwell_i : dwell_q;
   assign period_m1 = (dwell_src == '0) ? '0 : dwell_src - DWELL_W'(1);

   dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (accept),
      .en_i        ((state_q == ST_STEP) || (state_q == ST_FLASH)),
      .period_m1_i (period_m1),
      .tick_o      (tick)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         dwell_q    <= '0;
         steps_q    <= '0;
         step_cnt_q <= '0;
         button_q   <= 1'b0;
         sel_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         button_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q    <= state_for_mode(mode_i);
                  dwell_q    <= dwell_i;
                  steps_q    <= steps_i;
                  step_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  sel_q      <= (mode_i == MODE_HOLD);
               end
            end
            ST_STEP, ST_FLASH: begin
               if (stop_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  sel_q   <= 1'b0;
               end else if ((steps_q != '0) && (step_cnt_q == steps_q)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  sel_q   <= 1'b0;
                  done_q  <= 1'b1;
               end else if (tick) begin
                  // FLASH advances only on the falling half of the white toggle.
                  if ((state_q == ST_STEP) || sel_q) begin
                     button_q   <= 1'b1;
                     step_cnt_q <= step_cnt_q + STEP_W'(1);
                  end
                  if (state_q == ST_FLASH) begin
                     sel_q <= !sel_q;
                  end
               end
            end
            ST_HOLD: begin
               if (stop_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  sel_q   <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               sel_q   <= 1'b0;
            end
         endcase
      end
   end

   assign button_o   = button_q;
   assign sel_o      = sel_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign step_cnt_o = step_cnt_q;

endmodule

// File: tb/tb_light_sequencer.sv
// tb/tb_light_sequencer.sv - self-checking bench for light_sequencer against an elapsed-time model
module tb_light_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] dwell = 8'd0;
   logic [3:0] steps = 4'd0;
   logic       button, sel, busy, done;
   logic [3:0] step_cnt;

   always #5 clk = ~clk;

   light_sequencer #(.DWELL_W(8), .STEP_W(4)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .stop_i     (stop),
      .mode_i     (mode),
      .dwell_i    (dwell),
      .steps_i    (steps),
      .button_o   (button),
      .sel_o      (sel),
      .busy_o     (busy),
      .done_o     (done),
      .step_cnt_o (step_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: outputs derived from k = edges elapsed since the accepted start.
   int m_st = 0;   // 0 idle, 1 running, 2 done cycle
   int m_mode = 0, m_d = 1, m_steps = 0, m_k = 0;
   int exp_button = 0, exp_sel = 0, exp_busy = 0, exp_done = 0, exp_cnt = 0;

   function automatic int f_btn(input int md, input int k, input int d);
      if (md == 0) return int'(k % d == 0);
      if (md == 1) return int'((k % d == 0) && ((k / d) % 2 == 0));
      return 0;
   endfunction

   function automatic int f_sel(input int md, input int k, input int d);
      if (md == 1) return (k / d) % 2;
      return int'(md == 2);
   endfunction

   function automatic int f_cnt(input int md, input int k, input int d);
      if (md == 0) return (k / d) % 16;
      if (md == 1) return (k / (2 * d)) % 16;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 0; exp_button <= 0; exp_sel <= 0; exp_busy <= 0; exp_done <= 0; exp_cnt <= 0;
      end else begin
         exp_button <= 0;
         exp_done   <= 0;
         if (m_st == 0) begin
            if (start && !stop && mode != 2'b11) begin
               m_st <= 1; m_mode <= int'(mode); m_d <= (dwell == 0) ? 1 : int'(dwell);
               m_steps <= int'(steps); m_k <= 0;
               exp_cnt <= 0; exp_busy <= 1; exp_sel <= int'(mode == 2'b10);
            end
         end else if (m_st == 1) begin
            if (stop) begin
               m_st <= 0; exp_busy <= 0; exp_sel <= 0;
            end else if (m_mode != 2 && m_steps != 0 &&
                         m_k == m_steps * m_d * ((m_mode == 1) ? 2 : 1)) begin
               m_st <= 2; exp_busy <= 0; exp_sel <= 0; exp_done <= 1;
            end else begin
               m_k        <= m_k + 1;
               exp_button <= f_btn(m_mode, m_k + 1, m_d);
               exp_sel    <= f_sel(m_mode, m_k + 1, m_d);
               exp_cnt    <= f_cnt(m_mode, m_k + 1, m_d);
            end
         end else begin
            m_st <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_button", int'(button), exp_button);
         chk("model_sel", int'(sel), exp_sel);
         chk("model_busy", int'(busy), exp_busy);
         chk("model_done", int'(done), exp_done);
         chk("model_step_cnt", int'(step_cnt), exp_cnt);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns just after the edge that samples start (edge 0).
   task automatic go(input int m, input int d, input int s);
      mode = 2'(m); dwell = 8'(d); steps = 4'(s); start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   initial begin
      cyc(3);
      chk("reset_busy", int'(busy), 0);
      chk("reset_step_cnt", int'(step_cnt), 0);
      chk("reset_sel", int'(sel), 0);
      rst_n = 1'b1;
      chk_on = 1'b1;
      cyc(2);

      go(0, 5, 3);
      for (int c = 1; c <= 17; c++) begin
         cyc(1);
         chk("step_button", int'(button), int'(c == 5 || c == 10 || c == 15));
         chk("step_done", int'(done), int'(c == 16));
         chk("step_busy", int'(busy), int'(c <= 15));
         chk("step_cnt", int'(step_cnt), (c >= 15) ? 3 : c / 5);
      end

      go(1, 2, 2);
      for (int c = 1; c <= 10; c++) begin
         cyc(1);
         chk("flash_sel", int'(sel), int'((c >= 2 && c < 4) || (c >= 6 && c < 8)));
         chk("flash_button", int'(button), int'(c == 4 || c == 8));
         chk("flash_done", int'(done), int'(c == 9));
      end

      go(2, 9, 1);
      for (int c = 1; c <= 19; c++) begin
         cyc(1);
         chk("hold_sel", int'(sel), 1);
         chk("hold_button", int'(button), 0);
      end
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("hold_stop_sel", int'(sel), 0);
      chk("hold_stop_busy", int'(busy), 0);
      for (int c = 0; c < 3; c++) begin
         cyc(1);
         chk("hold_no_done", int'(done), 0);
      end

      go(1, 3, 0);
      cyc(4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_sel", int'(sel), 0);
      chk("async_rst_cnt", int'(step_cnt), 0);
      cyc(2);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cyc(1);
         chk("post_rst_idle", int'(busy), 0);
      end

      go(0, 0, 0);
      for (int c = 1; c <= 4; c++) begin
         cyc(1);
         chk("dwell0_button", int'(button), 1);
         chk("dwell0_cnt", int'(step_cnt), c);
      end
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("dwell0_stopped", int'(busy), 0);

      go(0, 1, 0);
      for (int c = 1; c <= 20; c++) begin
         cyc(1);
         chk("wrap_cnt", int'(step_cnt), c % 16);
      end
      stop = 1'b1; cyc(1); stop = 1'b0;

      go(0, 3, 0);
      cyc(2);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("stop_vs_tick_button", int'(button), 0);
      chk("stop_vs_tick_cnt", int'(step_cnt), 0);
      chk("stop_vs_tick_busy", int'(busy), 0);

      start = 1'b1; stop = 1'b1; mode = 2'b00;
      cyc(1);
      start = 1'b0; stop = 1'b0;
      chk("start_stop_idle", int'(busy), 0);

      go(3, 2, 2);
      chk("rsvd_busy", int'(busy), 0);
      cyc(3);
      chk("rsvd_button", int'(button), 0);

      for (int c = 0; c < 4000; c++) begin
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 59) == 0);
         mode  = 2'($urandom_range(0, 3));
         dwell = 8'($urandom_range(0, 5));
         steps = 4'($urandom_range(0, 4));
         cyc(1);
      end
      start = 1'b0; stop = 1'b0;
      cyc(2);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
